// File: rtl/mips_io_port_pkg.sv
// rtl/mips_io_port_pkg.sv - shared IN/OUT encodings, default sizes and stall helper
package mips_io_port_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int OUT_DEPTH_DEF  = 4;

    localparam logic [3:0] OP_IO    = 4'b1100;
    localparam logic [2:0] FUNK_IN  = 3'b000;
    localparam logic [2:0] FUNK_OUT = 3'b001;

    // Full is the registered flag, so a pop in the same cycle does not unstall an OUT.
    function automatic logic io_stall(input logic output_write, input logic out_full,
                                      input logic input_read, input logic in_full);
        return (output_write & out_full) | (input_read & ~in_full);
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// rtl/io_sync_fifo.sv - small synchronous FIFO with combinational head read
module io_sync_fifo
    import mips_io_port_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH = OUT_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // Caller guarantees push only when not full and pop only when not empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/mips_io_port.sv
// rtl/mips_io_port.sv - CPU endpoint for IN/OUT: OUT FIFO, IN holding register, IOStall
module mips_io_port
    import mips_io_port_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_DEPTH  = OUT_DEPTH_DEF
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  OutputWrite,
    input  logic [DATA_WIDTH-1:0] OutData,
    input  logic                  InputRead,
    output logic [DATA_WIDTH-1:0] InData,
    output logic                  IOStall,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready
);

    logic                  out_full;
    logic                  out_empty;
    logic                  out_push;
    logic                  out_pop;
    logic                  in_full_q, in_full_d;
    logic [DATA_WIDTH-1:0] in_hold_q, in_hold_d;
    logic                  in_capture;
    logic                  in_consume;

    assign out_valid = ~out_empty;
    assign out_push  = OutputWrite & ~out_full;
    assign out_pop   = out_valid & out_ready;

    io_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (CLK),
        .rst   (Reset),
        .push  (out_push),
        .pop   (out_pop),
        .wdata (OutData),
        .rdata (out_data),
        .full  (out_full),
        .empty (out_empty)
    );

    assign in_ready   = ~in_full_q;
    assign InData     = in_hold_q;
    assign in_capture = in_valid & ~in_full_q;
    assign in_consume = InputRead & in_full_q;
    assign IOStall    = io_stall(OutputWrite, out_full, InputRead, in_full_q);

    // Capture and consume are mutually exclusive since they depend on opposite in_full_q.
    always_comb begin
        in_full_d = in_full_q;
        in_hold_d = in_hold_q;
        if (in_consume) begin
            in_full_d = 1'b0;
        end
        if (in_capture) begin
            in_full_d = 1'b1;
            in_hold_d = in_data;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            in_full_q <= 1'b0;
            in_hold_q <= '0;
        end else begin
            in_full_q <= in_full_d;
            in_hold_q <= in_hold_d;
        end
    end

endmodule
